// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and keyboard receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ACK      = 8'hFA;

  // Device falling edges per host-to-device frame, ack included.
  localparam int FRAME_FALLS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status pulses between the system and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines and flags falling edges of the clock.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_k,
  input  logic reset_l,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] data_pipe;
  logic                   clk_prev;

  // NOTE: lines idle high, so resetting to 1 avoids a phantom fall right after reset.
  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      clk_pipe  <= '1;
      data_pipe <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_pipe  <= SYNC_STAGES'({clk_pipe, clk_raw});
      data_pipe <= SYNC_STAGES'({data_pipe, data_raw});
      clk_prev  <= clk_sync;
    end
  end

  assign clk_sync  = clk_pipe[SYNC_STAGES-1];
  assign data_sync = data_pipe[SYNC_STAGES-1];
  assign clk_fall  = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 10 bits, collect the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clk_k,
  input  logic         reset_l,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  import ps2_pkg::*;

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_IDX   = 4'(FRAME_FALLS - 2);
  localparam logic [3:0]       PARITY_IDX = STOP_IDX - 4'd1;

  tx_state_t        state;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             ack_bad;
  logic             done_q, ack_err_q, timeout_q;
  logic             clk_sync, data_sync, clk_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_k     (clk_k),
    .reset_l   (reset_l),
    .clk_raw   (ps2_clk_in),
    .data_raw  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_k or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      ack_bad     <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            data_q     <= bus.tx_data;
            parity_q   <= odd_parity(bus.tx_data);
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            wd_cnt      <= '0;
            bit_cnt     <= '0;
            state       <= SEND;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        SEND, ACK, WAIT_IDLE: begin
          // The completion pulse is shown while still busy, so no byte can be accepted alongside it.
          if (done_q || ack_err_q) begin
            state <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_q   <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (state == SEND && clk_fall) begin
              if (bit_cnt < PARITY_IDX) begin
                ps2_data_oe <= ~data_q[bit_cnt[2:0]];
              end else if (bit_cnt == PARITY_IDX) begin
                ps2_data_oe <= ~parity_q;
              end else begin
                ps2_data_oe <= 1'b0;
                state       <= ACK;
              end
              bit_cnt <= bit_cnt + 1'b1;
            end else if (state == ACK && clk_fall) begin
              ack_bad <= data_sync;
              state   <= WAIT_IDLE;
            end else if (state == WAIT_IDLE && clk_sync && data_sync) begin
              done_q    <= ~ack_bad;
              ack_err_q <= ack_bad;
            end
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready   = (state == IDLE);
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = done_q;
  assign bus.tx_ack_err = ack_err_q;
  assign bus.tx_timeout = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a PS/2 device model clocking at 1/40 of clk_k.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TMO = 2000;
  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_ERR  = 3'b010;
  localparam logic [2:0] EV_TMO  = 3'b100;

  typedef enum {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;

  logic clk_k = 1'b0;
  logic reset_l;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk, dev_data, dev_abort, dev_active;
  int   dev_bit;
  dev_mode_t dev_mode;

  int checks = 0;
  int failures = 0;
  logic [2:0]  exp_ev[$];
  logic [10:0] exp_frame[$];

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk_k       (clk_k),
    .reset_l     (reset_l),
    .bus         (bus.slave),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk_k = ~clk_k;

  // Open-collector lines: either side can pull low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Completion-pulse monitor: pops one expected event per observed pulse.
  always @(negedge clk_k) begin
    if (reset_l === 1'b1 && (bus.tx_done || bus.tx_ack_err || bus.tx_timeout)) begin
      if (exp_ev.size() == 0) fail_now("unexpected_pulse");
      else check("pulse_kind", {29'd0, bus.tx_timeout, bus.tx_ack_err, bus.tx_done}, exp_ev.pop_front());
    end
  end

  // Device model: samples the line just before each fall, acks on the 11th fall when told to.
  initial begin : device
    logic [10:0] captured;
    logic        aborted;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    dev_bit = 0;
    dev_active = 1'b0;
    wait (reset_l === 1'b1);
    forever begin
      @(negedge ps2_clk_oe);
      if (dev_mode == DEV_SILENT) continue;
      dev_active = 1'b1;
      aborted = 1'b0;
      captured = '0;
      repeat (10) @(negedge clk_k);
      for (int i = 0; i < 11; i++) begin
        dev_bit = i;
        if (dev_abort) begin aborted = 1'b1; break; end
        captured[i] = ps2_data_in;
        dev_clk = 1'b0;
        if (i == 10 && dev_mode == DEV_ACK) dev_data = 1'b0;
        repeat (20) @(negedge clk_k);
        if (dev_abort) begin aborted = 1'b1; break; end
        dev_clk = 1'b1;
        repeat (20) @(negedge clk_k);
      end
      dev_clk = 1'b1;
      if (!aborted) repeat (20) @(negedge clk_k);
      dev_data = 1'b1;
      if (!aborted) begin
        if (exp_frame.size() == 0) fail_now("unexpected_frame");
        else check("frame_bits", {21'd0, captured}, {21'd0, exp_frame.pop_front()});
      end
      dev_bit = 0;
      dev_active = 1'b0;
    end
  end

  // Issue one byte and check accept latency and inhibit length.
  task automatic send(input logic [7:0] data);
    int hi;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_k);
      if (bus.tx_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("ready_wait_expired");
    bus.tx_valid = 1'b1;
    bus.tx_data  = data;
    @(negedge clk_k);
    bus.tx_valid = 1'b0;
    check("accept_to_clk_oe", ps2_clk_oe, 1);
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_k);
      if (!ps2_clk_oe) break;
      hi++;
    end
    check("clk_oe_high_cycles", hi, INH);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_k);
      if (exp_ev.size() == 0 && bus.tx_ready && !dev_active) begin ok = 1; break; end
    end
    if (!ok) fail_now("completion_wait_expired");
    check("frames_drained", exp_frame.size(), 0);
    check("ready_after_frame", bus.tx_ready, 1);
  endtask

  task automatic wait_dev_bit(input int n);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_k);
      if (dev_bit == n) begin ok = 1; break; end
    end
    if (!ok) fail_now("dev_bit_wait_expired");
  endtask

  initial begin
    int cnt;
    reset_l = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    dev_mode = DEV_ACK;
    dev_abort = 1'b0;
    repeat (3) @(negedge clk_k);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_pulses", {bus.tx_timeout, bus.tx_ack_err, bus.tx_done}, 0);
    reset_l = 1'b1;
    repeat (5) @(negedge clk_k);

    // 0xED acked: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    exp_frame.push_back(11'b1_1_11101101_0);
    exp_ev.push_back(EV_DONE);
    send(8'hED);
    wait_idle();

    // 0x01: one set bit, parity 0
    exp_frame.push_back(11'b1_0_00000001_0);
    exp_ev.push_back(EV_DONE);
    send(8'h01);
    wait_idle();

    // 0xFF with the data line left high on the 11th fall
    dev_mode = DEV_NACK;
    exp_frame.push_back(11'b1_1_11111111_0);
    exp_ev.push_back(EV_ERR);
    send(8'hFF);
    wait_idle();

    // 0xEE with a silent device: watchdog expires TMO cycles after clock release
    dev_mode = DEV_SILENT;
    exp_ev.push_back(EV_TMO);
    send(8'hEE);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_k);
      cnt++;
      if (bus.tx_timeout) break;
    end
    check("timeout_cycles", cnt, TMO);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    wait_idle();

    // Reset during bit 4 of 0xED (bit 4 is 0, so data is being pulled low)
    dev_mode = DEV_ACK;
    send(8'hED);
    wait_dev_bit(5);
    check("bit4_data_oe", ps2_data_oe, 1);
    dev_abort = 1'b1;
    reset_l = 1'b0;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    check("rst_mid_busy", bus.tx_busy, 0);
    repeat (3) @(negedge clk_k);
    reset_l = 1'b1;
    wait_idle();
    dev_abort = 1'b0;

    // Clean 0xEE after the aborted frame
    exp_frame.push_back(11'b1_1_11101110_0);
    exp_ev.push_back(EV_DONE);
    send(8'hEE);
    wait_idle();

    // 0x55 offered mid-frame must be ignored
    exp_frame.push_back(11'b1_1_11101101_0);
    exp_ev.push_back(EV_DONE);
    send(8'hED);
    wait_dev_bit(3);
    check("ready_low_in_send", bus.tx_ready, 0);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h55;
    @(negedge clk_k);
    bus.tx_valid = 1'b0;
    wait_idle();
    repeat (50) @(negedge clk_k);
    check("no_extra_frame_clk_oe", ps2_clk_oe, 0);
    check("events_drained", exp_ev.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xEE echo.
- Mirror of the keyboard receive path. Runs in the FPGA system clock domain clk_k.
- Samples the open-collector PS/2 clock and data lines and drives them low through output-enables.
- Asserts tx_busy so the receive path ignores line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000: clk_k cycles the PS/2 clock is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: watchdog limit in clk_k cycles, from clock release to ack completion (15 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_in and ps2_data_in.

Ports:
- clk_k  in  1  system clock
- reset_l  in  1  asynchronous, active-low reset
- tx_valid  in  1  command byte available
- tx_data  in  8  command byte, LSB sent first
- tx_ready  out  1  block idle, can accept a byte
- ps2_clk_in  in  1  raw PS/2 clock line
- ps2_data_in  in  1  raw PS/2 data line
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release
- tx_busy  out  1  transmission in progress
- tx_done  out  1  one-cycle pulse: frame sent, device acked
- tx_ack_err  out  1  one-cycle pulse: ack bit sampled high
- tx_timeout  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Clock and reset: clock clk_k; reset reset_l, asynchronous, active-low.
- Reset values: state IDLE; ps2_clk_oe=0, ps2_data_oe=0; tx_busy=0; tx_done=0, tx_ack_err=0, tx_timeout=0; tx_ready=1.
- Edge detection:
  - Both lines pass through a SYNC_STAGES flop synchronizer.
  - fall = previous synced clock high AND current synced clock low. One-cycle pulse.
- Handshake:
  - tx_ready = (state==IDLE).
  - A byte is accepted on a cycle with tx_valid && tx_ready. That cycle latches tx_data and parity = ~^tx_data (odd parity).
  - tx_valid outside IDLE is ignored; no queuing.
- State machine:
  - IDLE: on accept -> INHIBIT, counter cleared, ps2_clk_oe=1.
  - INHIBIT: count INHIBIT_CYCLES cycles. Then ps2_data_oe=1 (start bit), ps2_clk_oe=0, watchdog cleared -> SEND, bit_cnt=0.
  - SEND: on each fall, drive the next bit and increment bit_cnt:
    - bit_cnt 0..7: ps2_data_oe = ~data[bit_cnt].
    - bit_cnt 8: ps2_data_oe = ~parity.
    - bit_cnt 9: ps2_data_oe=0 (stop bit, line released) -> ACK.
  - ACK: on the next fall, sample synced data:
    - 0 -> WAIT_IDLE with ack ok.
    - 1 -> WAIT_IDLE with ack error flag set.
  - WAIT_IDLE: wait until both synced lines are high. Then pulse tx_done (ack ok) or tx_ack_err (ack error) -> IDLE.
- Total device falling edges per frame: 11 (start sampled by device + 8 data + parity + stop, then ack).
- tx_busy = (state != IDLE).
- Watchdog:
  - Runs in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: both oe=0, pulse tx_timeout, -> IDLE.
  - If a fall and expiry occur in the same cycle, timeout wins and the edge is discarded.
- Boundary conditions:
  - No fall during INHIBIT has any effect; the device cannot clock while the host holds the clock low.
  - reset_l asserted mid-frame: both oe released immediately (asynchronously); no pulse emitted.
  - Accept in the same cycle tx_done pulses: impossible. tx_ready is low until the cycle after the pulse (IDLE entered).
  - Counter widths: $clog2 of each cycle parameter, +1 bit; no wrap inside a frame.
- Latency:
  - Accept to ps2_clk_oe=1: 1 cycle.
  - ps2_clk_oe high for exactly INHIBIT_CYCLES cycles.

Decomposition:
- Package ps2_pkg:
  - state enum tx_state_t {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE}.
  - Constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF, CMD_ACK=8'hFA.
  - Constant FRAME_FALLS=11.
- Sub-module ps2_line_sync: synchronizer plus falling-edge detector, parameterized by SYNC_STAGES. Reusable by the receiver.

Test Plan:
Bench runs INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000, with a device model clocking at 1/40 of clk_k.
- Send 0xED, model acks -> ps2_clk_oe high exactly 10 cycles; model captures start 0, data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; tx_done pulses once; tx_ready returns to 1.
- Send 0x01 -> parity bit 0 captured; tx_done pulses.
- Send 0xFF, model holds data high on the 11th fall -> tx_ack_err pulses, tx_done stays 0, back to IDLE.
- Send 0xEE, model never clocks -> tx_timeout pulses 2000 cycles after clock release; both oe=0.
- Assert reset_l low during bit 4 of 0xED -> both oe=0 in the same cycle; tx_busy=0; no pulses; next 0xEE sends cleanly.
- Pulse tx_valid with 0x55 during SEND of 0xED -> ignored; model receives only 0xED.
